// File: rtl/lane_cond_pkg.sv
// Shared types and constants for the per-lane conditional-execution unit.
// Latency: n/a (declarations only); backpressure: n/a.
package lane_cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_t;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/condcheck.sv
// Single-lane condition evaluation against one {N,Z,C,V} flag nibble.
// Latency: combinational; backpressure: none.
module condcheck
  import lane_cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[N];
  assign z  = Flags[Z];
  assign c  = Flags[C];
  assign v  = Flags[V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      EQ:      CondEx = z;
      NE:      CondEx = ~z;
      CS:      CondEx = c;
      CC:      CondEx = ~c;
      MI:      CondEx = n;
      PL:      CondEx = ~n;
      VS:      CondEx = v;
      VC:      CondEx = ~v;
      HI:      CondEx = ~z & c;
      LS:      CondEx = z | ~c;
      GE:      CondEx = ge;
      LT:      CondEx = ~ge;
      GT:      CondEx = ~z & ge;
      LE:      CondEx = z | ~ge;
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mask_stack.sv
// Bounded LIFO of saved lane masks; push on full and pop on empty are dropped.
// Latency: writes visible next cycle, top is combinational; backpressure: none.
module mask_stack
  import lane_cond_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [LANES-1:0] din,
  output logic [LANES-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int SPW = sp_width(DEPTH);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LANES-1:0] mem [DEPTH];
  logic [SPW-1:0]   sp;
  logic [IW-1:0]    wr_idx, rd_idx;

  assign full   = (sp == SPW'(DEPTH));
  assign empty  = (sp == '0);
  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - SPW'(1));
  assign top    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

  // Entries above the pointer are dead, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/lane_condlogic.sv
// Per-lane condition evaluation, write gating and if/else/endif lane masking.
// Latency: enables combinational, state visible next cycle; backpressure: none.
module lane_condlogic
  import lane_cond_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FlushE,
  input  logic               PCS,
  input  logic               RegW,
  input  logic               MemW,
  input  logic               NoWrite,
  input  logic               B,
  input  logic               Else,
  input  logic               EndIf,
  input  logic [1:0]         FlagW,
  input  logic [3:0]         Cond,
  input  logic [4*LANES-1:0] ALUFlags,
  output logic               PCSrc,
  output logic               BranchTakenE,
  output logic [LANES-1:0]   RegWrite,
  output logic [LANES-1:0]   MemWrite,
  output logic [LANES-1:0]   ActiveMask,
  output logic               Diverge,
  output logic               StackFull,
  output logic               StackEmpty,
  output logic               Overflow,
  output logic               Underflow
);

  logic [4*LANES-1:0] flags_q;
  logic [LANES-1:0]   mask_q, mask_nxt, cc_raw, condex, stk_top;
  logic all_true, none_true, mixed;
  logic do_b, do_else, do_endif, push, pop, ovf_set, unf_set;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    condcheck u_cc (
      .Cond   (Cond),
      .Flags  (flags_q[4*g +: 4]),
      .CondEx (cc_raw[g])
    );
  end

  assign condex    = cc_raw & mask_q & {LANES{~FlushE}};
  assign all_true  = (|mask_q) && (condex == mask_q);
  assign none_true = (condex == '0);
  assign mixed     = ~all_true & ~none_true;

  assign RegWrite     = condex & {LANES{RegW & ~NoWrite}};
  assign MemWrite     = condex & {LANES{MemW}};
  assign PCSrc        = PCS & all_true;
  assign BranchTakenE = B & all_true;
  assign ActiveMask   = mask_q;

  // B outranks EndIf, which outranks Else; a flush cancels all three.
  assign do_b     = B & ~FlushE;
  assign do_endif = EndIf & ~B & ~FlushE;
  assign do_else  = Else & ~EndIf & ~B & ~FlushE;

  assign push    = do_b & mixed & ~StackFull;
  assign pop     = do_endif & ~StackEmpty;
  assign ovf_set = do_b & mixed & StackFull;
  assign unf_set = (do_endif | do_else) & StackEmpty;
  assign Diverge = push;

  always_comb begin
    mask_nxt = mask_q;
    if (push)                       mask_nxt = mask_q & ~condex;
    else if (pop)                   mask_nxt = stk_top;
    else if (do_else & ~StackEmpty) mask_nxt = stk_top & ~mask_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flags_q   <= '0;
      mask_q    <= '1;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (FlagW[1] & condex[i]) flags_q[4*i+N -: 2] <= ALUFlags[4*i+N -: 2];
        if (FlagW[0] & condex[i]) flags_q[4*i+C -: 2] <= ALUFlags[4*i+C -: 2];
      end
      mask_q <= mask_nxt;
      if (ovf_set) Overflow  <= 1'b1;
      if (unf_set) Underflow <= 1'b1;
    end
  end

  mask_stack #(.LANES(LANES), .DEPTH(DEPTH)) u_stack (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (mask_q),
    .top   (stk_top),
    .full  (StackFull),
    .empty (StackEmpty)
  );

endmodule

// File: tb/tb_lane_condlogic.sv
// Directed-vector bench for lane_condlogic with LANES=4, DEPTH=2.
// Latency: n/a; backpressure: n/a.
module tb_lane_condlogic;

  logic        CLK, RST, FlushE, PCS, RegW, MemW, NoWrite, B, Else, EndIf;
  logic [1:0]  FlagW;
  logic [3:0]  Cond;
  logic [15:0] ALUFlags;
  logic        PCSrc, BranchTakenE, Diverge, StackFull, StackEmpty, Overflow, Underflow;
  logic [3:0]  RegWrite, MemWrite, ActiveMask;

  int n_checks = 0;
  int n_fail   = 0;

  lane_condlogic #(.LANES(4), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .FlushE(FlushE), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .B(B), .Else(Else), .EndIf(EndIf), .FlagW(FlagW),
    .Cond(Cond), .ALUFlags(ALUFlags), .PCSrc(PCSrc), .BranchTakenE(BranchTakenE),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ActiveMask(ActiveMask),
    .Diverge(Diverge), .StackFull(StackFull), .StackEmpty(StackEmpty),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    FlushE = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    B = 0; Else = 0; EndIf = 0; FlagW = 2'b00; Cond = 4'h0; ALUFlags = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    clr();
  endtask

  // Cond=AL flag load; only currently active lanes take it.
  task automatic load(input logic [1:0] fw, input logic [15:0] fl);
    Cond = 4'hE; FlagW = fw; ALUFlags = fl;
    tick();
  endtask

  initial begin
    CLK = 0; RST = 1; clr();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_mask",  ActiveMask, 4'b1111);
    chk("rst_empty", StackEmpty, 1);
    chk("rst_full",  StackFull,  0);
    chk("rst_ovf",   Overflow,   0);
    chk("rst_unf",   Underflow,  0);
    chk("rst_rw",    RegWrite,   4'b0000);
    RST = 0;

    Cond = 4'hE; RegW = 1; MemW = 1; #1;
    chk("al_rw", RegWrite, 4'b1111);
    chk("al_mw", MemWrite, 4'b1111);
    chk("al_pcsrc", PCSrc, 0);
    tick();
    Cond = 4'hE; RegW = 1; NoWrite = 1; #1;
    chk("nowrite_rw", RegWrite, 4'b0000);
    tick();
    Cond = 4'hF; RegW = 1; #1;
    chk("nv_rw", RegWrite, 4'b0000);
    tick();

    // NZ-only load: lanes 0,2 get Z, lane 1 offers C which must be ignored.
    load(2'b10, 16'h0424);
    Cond = 4'h0; MemW = 1; ALUFlags = 16'h4444; #1;
    chk("eq_mw_old_flags", MemWrite, 4'b0101);
    tick();
    Cond = 4'h1; MemW = 1; #1;
    chk("ne_mw", MemWrite, 4'b1010);
    tick();
    Cond = 4'h2; MemW = 1; #1;
    chk("cs_mw_nz_only", MemWrite, 4'b0000);
    tick();
    load(2'b01, 16'h0020);
    Cond = 4'h2; MemW = 1; #1;
    chk("cs_mw_cv", MemWrite, 4'b0010);
    tick();
    Cond = 4'h0; MemW = 1; #1;
    chk("eq_mw_nz_kept", MemWrite, 4'b0101);
    tick();

    // Divergence / else / endif
    load(2'b11, 16'h0044);
    Cond = 4'h0; B = 1; #1;
    chk("div_bt", BranchTakenE, 0);
    chk("div_diverge", Diverge, 1);
    tick();
    chk("div_mask", ActiveMask, 4'b1100);
    chk("div_nonempty", StackEmpty, 0);
    Cond = 4'hE; RegW = 1; #1;
    chk("body_rw", RegWrite, 4'b1100);
    tick();
    Else = 1; #1;
    chk("else_diverge", Diverge, 0);
    tick();
    chk("else_mask", ActiveMask, 4'b0011);
    EndIf = 1;
    tick();
    chk("endif_mask", ActiveMask, 4'b1111);
    chk("endif_empty", StackEmpty, 1);

    // Uniform branches
    load(2'b10, 16'h4444);
    Cond = 4'h0; B = 1; #1;
    chk("uni_bt", BranchTakenE, 1);
    chk("uni_diverge", Diverge, 0);
    tick();
    chk("uni_mask", ActiveMask, 4'b1111);
    chk("uni_empty", StackEmpty, 1);
    Cond = 4'h1; B = 1; #1;
    chk("none_bt", BranchTakenE, 0);
    chk("none_diverge", Diverge, 0);
    tick();
    load(2'b10, 16'h0044);
    Cond = 4'h0; B = 1;
    tick();
    chk("sub_mask", ActiveMask, 4'b1100);
    load(2'b10, 16'h4400);
    Cond = 4'h0; B = 1; PCS = 1; #1;
    chk("sub_bt", BranchTakenE, 1);
    chk("sub_pcsrc", PCSrc, 1);
    chk("sub_diverge", Diverge, 0);
    tick();
    chk("sub_mask_kept", ActiveMask, 4'b1100);
    Cond = 4'hE; B = 1; EndIf = 1; #1;
    chk("prio_bt", BranchTakenE, 1);
    tick();
    chk("prio_mask", ActiveMask, 4'b1100);
    chk("prio_nonempty", StackEmpty, 0);
    EndIf = 1;
    tick();
    chk("sub_endif_mask", ActiveMask, 4'b1111);

    // Nesting past DEPTH
    load(2'b10, 16'h0004);
    Cond = 4'h0; B = 1; #1;
    chk("nest1_diverge", Diverge, 1);
    tick();
    chk("nest1_mask", ActiveMask, 4'b1110);
    load(2'b10, 16'h0040);
    Cond = 4'h0; B = 1; #1;
    chk("nest2_diverge", Diverge, 1);
    tick();
    chk("nest2_mask", ActiveMask, 4'b1100);
    chk("nest2_full", StackFull, 1);
    load(2'b10, 16'h0400);
    Cond = 4'h0; B = 1; #1;
    chk("nest3_diverge", Diverge, 0);
    chk("nest3_bt", BranchTakenE, 0);
    tick();
    chk("nest3_mask", ActiveMask, 4'b1100);
    chk("nest3_ovf", Overflow, 1);
    EndIf = 1;
    tick();
    chk("pop1_mask", ActiveMask, 4'b1110);
    chk("ovf_sticky", Overflow, 1);
    EndIf = 1;
    tick();
    chk("pop2_mask", ActiveMask, 4'b1111);
    chk("pop2_empty", StackEmpty, 1);
    chk("pop2_unf", Underflow, 0);
    EndIf = 1;
    tick();
    chk("unf_set", Underflow, 1);
    chk("unf_mask", ActiveMask, 4'b1111);

    // Flush suppresses enables and all state updates
    load(2'b10, 16'h0044);
    FlushE = 1; Cond = 4'h0; B = 1; PCS = 1; RegW = 1; MemW = 1;
    FlagW = 2'b11; ALUFlags = 16'h4444; #1;
    chk("flush_rw", RegWrite, 4'b0000);
    chk("flush_mw", MemWrite, 4'b0000);
    chk("flush_bt", BranchTakenE, 0);
    chk("flush_diverge", Diverge, 0);
    chk("flush_pcsrc", PCSrc, 0);
    tick();
    chk("flush_empty", StackEmpty, 1);
    chk("flush_mask", ActiveMask, 4'b1111);
    Cond = 4'h0; MemW = 1; #1;
    chk("flush_flags_kept", MemWrite, 4'b0011);
    tick();

    // Asynchronous reset mid-nesting
    Cond = 4'h0; B = 1;
    tick();
    chk("pre_rst_mask", ActiveMask, 4'b1100);
    #2 RST = 1;
    #1;
    chk("arst_mask",  ActiveMask, 4'b1111);
    chk("arst_empty", StackEmpty, 1);
    chk("arst_ovf",   Overflow,   0);
    chk("arst_unf",   Underflow,  0);
    #3 RST = 0;
    tick();
    chk("post_rst_mask", ActiveMask, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_condlogic.md
# lane_condlogic

Per-lane conditional-execution unit for the SIMD Filter-GPU execute stage. It holds one NZCV flag register per lane and evaluates the instruction condition independently in every lane. It gates per-lane register and memory writes with the result. It also maintains an active-lane mask with a bounded predication stack, so divergent branches are handled with if/else/endif masking instead of a PC change.

## Interface
- LANES, default 4: number of datapath lanes (≥1).
- DEPTH, default 4: predication stack entries (≥1).
- CLK  in  1: clock, all state updates on rising edge.
- RST  in  1: reset, asynchronous, active-high.
- FlushE  in  1: squashes the execute-stage instruction; no state update, all enables 0.
- PCS, RegW, MemW, NoWrite, B  in  1 each: decoded execute-stage controls.
- Else, EndIf  in  1 each: predication-control instructions.
- FlagW  in  2: [1] enables NZ write, [0] enables CV write.
- Cond  in  4: condition code.
- ALUFlags  in  4*LANES: lane i flags at [4i+3:4i] = {N,Z,C,V}.
- PCSrc  out  1: PC-writing instruction takes effect.
- BranchTakenE  out  1: uniform branch taken.
- RegWrite, MemWrite  out  LANES each: per-lane write enables.
- ActiveMask  out  LANES: current active lanes.
- Diverge  out  1: current instruction is a divergent branch, pushed.
- StackFull, StackEmpty  out  1 each: stack status.
- Overflow, Underflow  out  1 each: sticky error flags, cleared only by RST.

## Operation
- **Per-lane condition.** CondEx[i] = condcheck(Flags[i], Cond) & ActiveMask[i] & ~FlushE. Cond 4'b1110 (AL) is true; 4'b1111 is false.
- **Per-lane enables.** RegWrite[i] = RegW & CondEx[i] & ~NoWrite. MemWrite[i] = MemW & CondEx[i].
- **Flag update.** Lane i NZ is loaded when FlagW[1] & CondEx[i]. Lane i CV is loaded when FlagW[0] & CondEx[i].
- **Lane agreement terms.**
  - AllTrue = (|ActiveMask) & (CondEx == ActiveMask).
  - NoneTrue = (CondEx == 0).
  - Mixed = ~AllTrue & ~NoneTrue.
- **PCSrc.** PCSrc = PCS & AllTrue.
- **B, uniform.** AllTrue gives BranchTakenE = 1. Otherwise BranchTakenE = 0.
- **B, Mixed, stack not full.**
  - Diverge = 1.
  - Push ActiveMask.
  - ActiveMask ← ActiveMask & ~CondEx, i.e. the fall-through lanes run the body.
- **B, Mixed, stack full.** No push, mask unchanged, Diverge = 0, Overflow ← 1.
- **Else.**
  - Stack not empty: ActiveMask ← top & ~ActiveMask, no pop.
  - Stack empty: no change, Underflow ← 1.
- **EndIf.**
  - Stack not empty: ActiveMask ← top, then pop.
  - Stack empty: no change, Underflow ← 1.
- **Simultaneous controls.** Priority is B > EndIf > Else; lower-priority controls are ignored that cycle.
- **FlushE = 1.** Suppresses every flag, mask, stack and error update, and forces every output enable to 0.
- **Zero mask.** ActiveMask = 0 is legal: all enables are 0, and B is treated as not taken.
- **Reset values.**
  - Flags all 0, ActiveMask all 1s, stack empty with pointer 0.
  - Overflow = Underflow = 0.
  - PCSrc, BranchTakenE, RegWrite, MemWrite and Diverge are combinational, hence 0 unless inputs assert.

## Timing
- All outputs except the status bits are combinational from the inputs and current state, within the same cycle.
- Flag, mask and stack writes in cycle t are visible to the instruction in cycle t+1. There is no bypass of same-cycle ALUFlags into the condition.
- StackFull, StackEmpty, Overflow and Underflow reflect registered state.
- RST asserted mid-sequence discards stack contents at once and restores the all-ones mask.

## Structure
- Package lane_cond_pkg:
  - cond_t enum (EQ=0 … AL=14, NV=15).
  - Flag index constants N=3, Z=2, C=1, V=0.
  - A stack-pointer width function, $clog2(DEPTH+1).
- Sub-module mask_stack:
  - Parameters LANES, DEPTH; ports push, pop, din, top, full, empty.
  - Push on full and pop on empty are ignored internally.
- Instantiate the existing condcheck once per lane in a generate loop.

## Test plan
Benches use LANES=4, DEPTH=2.
- **Reset, then write.** Cond=AL, RegW=1 → RegWrite=4'b1111, ActiveMask=4'b1111, StackEmpty=1.
- **Per-lane flags.** Load lane Z flags 4'b0101 via FlagW=2'b10, then Cond=EQ, MemW=1 next cycle → MemWrite=4'b0101, same-cycle MemWrite using old flags.
- **Divergence.** Cond=EQ, B=1 with Z=4'b0011 → BranchTakenE=0, Diverge=1, next ActiveMask=4'b1100. Else → 4'b0011. EndIf → 4'b1111, StackEmpty=1.
- **Uniform branch.** Z=4'b1111, B, EQ → BranchTakenE=1, mask unchanged. Same with ActiveMask=4'b1100, Z=4'b1100 → taken, and PCSrc=1 with PCS=1.
- **Overflow.** Three nested divergent branches → third gives Diverge=0, Overflow=1 sticky, mask unchanged. EndIf with empty stack → Underflow=1.
- **Flush and reset.** FlushE=1 during a divergent B → no push, all enables 0. RST asserted mid-nesting → mask 4'b1111, stack empty, Overflow/Underflow cleared.
